// File: rtl/fp_addsub_if.sv
// Operand/result bundle for fp_addsub: one op enters with start, one result
// leaves with done; status flags are only meaningful alongside done.
interface fp_addsub_if #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
);
  localparam int DATA_W = 1 + EXP_W + MAN_W;

  logic              start;
  logic              sub;
  logic [DATA_W-1:0] op_a;
  logic [DATA_W-1:0] op_b;
  logic              done;
  logic [DATA_W-1:0] res;
  logic              overflow;
  logic              underflow;
  logic              exception;

  modport master (
    output start, sub, op_a, op_b,
    input  done, res, overflow, underflow, exception
  );

  modport slave (
    input  start, sub, op_a, op_b,
    output done, res, overflow, underflow, exception
  );
endinterface

// File: rtl/fp_addsub.sv
// Four-stage pipelined floating-point adder/subtractor with flush-to-zero,
// round-to-nearest-even and IEEE-style special-value handling.
module fp_addsub #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic       clk,
  input  logic       rst,
  fp_addsub_if.slave bus
);
  localparam int DATA_W = 1 + EXP_W + MAN_W;
  localparam int SIG_W  = MAN_W + 1;
  localparam int W      = MAN_W + 4;
  localparam int XW     = 2 * MAN_W + 4;
  localparam int SHW    = $clog2(MAN_W + 4);
  localparam int LZW    = $clog2(W + 1);
  localparam int EW     = EXP_W + 2;
  localparam int MAX_SH = MAN_W + 3;
  localparam logic signed [EW-1:0] EXP_INF = EW'((1 << EXP_W) - 1);
  localparam logic [DATA_W-1:0]    QNAN    = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

  function automatic logic [LZW-1:0] lzc(input logic [W-1:0] v);
    logic [LZW-1:0] n;
    n = LZW'(W);
    for (int i = 0; i < W; i++) begin
      if (v[i]) n = LZW'(W - 1 - i);
    end
    return n;
  endfunction

  // ---------------- stage 1: classify, swap, exponent difference
  logic             sa, sb, a_zero, b_zero, a_inf, b_inf, a_nan, b_nan, swap;
  logic [EXP_W-1:0] ea, eb;
  logic [MAN_W-1:0] fa, fb;

  assign sa     = bus.op_a[DATA_W-1];
  assign sb     = bus.op_b[DATA_W-1] ^ bus.sub;
  assign ea     = bus.op_a[DATA_W-2 -: EXP_W];
  assign eb     = bus.op_b[DATA_W-2 -: EXP_W];
  assign fa     = bus.op_a[MAN_W-1:0];
  assign fb     = bus.op_b[MAN_W-1:0];
  assign a_zero = (ea == '0);
  assign b_zero = (eb == '0);
  assign a_inf  = (ea == '1) && (fa == '0);
  assign b_inf  = (eb == '1) && (fb == '0);
  assign a_nan  = (ea == '1) && (fa != '0);
  assign b_nan  = (eb == '1) && (fb != '0);
  assign swap   = {eb, fb} > {ea, fa};

  logic              byp_next, byp_exc_next;
  logic [DATA_W-1:0] byp_res_next;

  // Anything involving NaN, infinity or a (flushed) zero never needs the adder.
  always_comb begin
    byp_next     = 1'b1;
    byp_exc_next = 1'b0;
    byp_res_next = '0;
    if (a_nan || b_nan || (a_inf && b_inf && (sa != sb))) begin
      byp_res_next = QNAN;
      byp_exc_next = 1'b1;
    end else if (a_inf) begin
      byp_res_next = {sa, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    end else if (b_inf) begin
      byp_res_next = {sb, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    end else if (a_zero && b_zero) begin
      byp_res_next = {sa & sb, {(DATA_W-1){1'b0}}};
    end else if (b_zero) begin
      byp_res_next = bus.op_a;
    end else if (a_zero) begin
      byp_res_next = {sb, bus.op_b[DATA_W-2:0]};
    end else begin
      byp_next = 1'b0;
    end
  end

  logic             big_sign;
  logic [EXP_W-1:0] big_exp, small_exp, exp_diff;
  logic [SIG_W-1:0] big_sig, small_sig;
  logic [SHW-1:0]   shift_next;

  always_comb begin
    big_sign   = swap ? sb : sa;
    big_exp    = swap ? eb : ea;
    small_exp  = swap ? ea : eb;
    big_sig    = swap ? {1'b1, fb} : {1'b1, fa};
    small_sig  = swap ? {1'b1, fa} : {1'b1, fb};
    exp_diff   = big_exp - small_exp;
    shift_next = (32'(exp_diff) > 32'(MAX_SH)) ? SHW'(MAX_SH) : SHW'(exp_diff);
  end

  logic              s1_valid_reg, s1_byp_reg, s1_exc_reg, s1_sign_reg, s1_eff_sub_reg;
  logic [DATA_W-1:0] s1_byp_res_reg;
  logic [EXP_W-1:0]  s1_exp_reg;
  logic [SIG_W-1:0]  s1_big_reg, s1_small_reg;
  logic [SHW-1:0]    s1_shift_reg;

  always_ff @(posedge clk) begin
    if (rst) s1_valid_reg <= 1'b0;
    else     s1_valid_reg <= bus.start;
    s1_byp_reg     <= byp_next;
    s1_exc_reg     <= byp_exc_next;
    s1_byp_res_reg <= byp_res_next;
    s1_sign_reg    <= big_sign;
    s1_eff_sub_reg <= sa ^ sb;
    s1_exp_reg     <= big_exp;
    s1_big_reg     <= big_sig;
    s1_small_reg   <= small_sig;
    s1_shift_reg   <= shift_next;
  end

  // ---------------- stage 2: align smaller significand, add/subtract
  logic [XW-1:0] ext_shifted;
  logic [W-1:0]  aligned;
  logic [W:0]    sum_next;

  always_comb begin
    ext_shifted = {s1_small_reg, {(MAN_W+3){1'b0}}} >> s1_shift_reg;
    // Low bits below the sticky position all collapse into sticky.
    aligned     = {ext_shifted[XW-1 -: W-1], ext_shifted[MAN_W] | (|ext_shifted[MAN_W-1:0])};
    if (s1_eff_sub_reg) sum_next = {1'b0, s1_big_reg, 3'b000} - {1'b0, aligned};
    else                sum_next = {1'b0, s1_big_reg, 3'b000} + {1'b0, aligned};
  end

  logic              s2_valid_reg, s2_byp_reg, s2_exc_reg, s2_sign_reg;
  logic [DATA_W-1:0] s2_byp_res_reg;
  logic [EXP_W-1:0]  s2_exp_reg;
  logic [W:0]        s2_sum_reg;

  always_ff @(posedge clk) begin
    if (rst) s2_valid_reg <= 1'b0;
    else     s2_valid_reg <= s1_valid_reg;
    s2_byp_reg     <= s1_byp_reg;
    s2_exc_reg     <= s1_exc_reg;
    s2_byp_res_reg <= s1_byp_res_reg;
    s2_sign_reg    <= s1_sign_reg;
    s2_exp_reg     <= s1_exp_reg;
    s2_sum_reg     <= sum_next;
  end

  // ---------------- stage 3: normalise
  logic [LZW-1:0]       lz;
  logic [W-1:0]         norm_next;
  logic signed [EW-1:0] exp_norm_next;
  logic                 zero_next;

  always_comb begin
    lz        = lzc(s2_sum_reg[W-1:0]);
    zero_next = (s2_sum_reg == '0);
    if (s2_sum_reg[W]) begin
      norm_next     = {s2_sum_reg[W:2], s2_sum_reg[1] | s2_sum_reg[0]};
      exp_norm_next = EW'(s2_exp_reg) + EW'(1);
    end else begin
      norm_next     = s2_sum_reg[W-1:0] << lz;
      exp_norm_next = EW'(s2_exp_reg) - EW'(lz);
    end
  end

  logic                 s3_valid_reg, s3_byp_reg, s3_exc_reg, s3_sign_reg, s3_zero_reg;
  logic [DATA_W-1:0]    s3_byp_res_reg;
  logic signed [EW-1:0] s3_exp_reg;
  logic [W-1:0]         s3_norm_reg;

  always_ff @(posedge clk) begin
    if (rst) s3_valid_reg <= 1'b0;
    else     s3_valid_reg <= s2_valid_reg;
    s3_byp_reg     <= s2_byp_reg;
    s3_exc_reg     <= s2_exc_reg;
    s3_byp_res_reg <= s2_byp_res_reg;
    s3_sign_reg    <= s2_sign_reg;
    s3_zero_reg    <= zero_next;
    s3_exp_reg     <= exp_norm_next;
    s3_norm_reg    <= norm_next;
  end

  // ---------------- stage 4: round, range check, output register
  logic [SIG_W-1:0]     mant;
  logic [SIG_W:0]       mant_rnd;
  logic                 round_up;
  logic signed [EW-1:0] exp_rnd;
  logic [MAN_W-1:0]     frac_rnd;
  logic [DATA_W-1:0]    res_next;
  logic                 ovf_next, unf_next, exc_next;

  always_comb begin
    mant     = s3_norm_reg[W-1:3];
    round_up = s3_norm_reg[2] & (s3_norm_reg[1] | s3_norm_reg[0] | mant[0]);
    mant_rnd = {1'b0, mant} + {{SIG_W{1'b0}}, round_up};
    exp_rnd  = s3_exp_reg + EW'(mant_rnd[SIG_W]);
    frac_rnd = mant_rnd[SIG_W] ? mant_rnd[MAN_W:1] : mant_rnd[MAN_W-1:0];
    res_next = '0;
    ovf_next = 1'b0;
    unf_next = 1'b0;
    exc_next = 1'b0;
    if (s3_byp_reg) begin
      res_next = s3_byp_res_reg;
      exc_next = s3_exc_reg;
    end else if (s3_zero_reg) begin
      res_next = '0;
    end else if (!exp_rnd[EW-1] && (exp_rnd >= EXP_INF)) begin
      res_next = {s3_sign_reg, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      ovf_next = 1'b1;
    end else if (exp_rnd[EW-1] || (exp_rnd == '0)) begin
      res_next = {s3_sign_reg, {(DATA_W-1){1'b0}}};
      unf_next = 1'b1;
    end else begin
      res_next = {s3_sign_reg, exp_rnd[EXP_W-1:0], frac_rnd};
    end
  end

  logic              done_reg, ovf_reg, unf_reg, exc_reg;
  logic [DATA_W-1:0] res_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      done_reg <= 1'b0;
      res_reg  <= '0;
      ovf_reg  <= 1'b0;
      unf_reg  <= 1'b0;
      exc_reg  <= 1'b0;
    end else begin
      done_reg <= s3_valid_reg;
      if (s3_valid_reg) begin
        res_reg <= res_next;
        ovf_reg <= ovf_next;
        unf_reg <= unf_next;
        exc_reg <= exc_next;
      end
    end
  end

  assign bus.done      = done_reg;
  assign bus.res       = res_reg;
  assign bus.overflow  = ovf_reg;
  assign bus.underflow = unf_reg;
  assign bus.exception = exc_reg;
endmodule

// File: tb/tb_fp_addsub.sv
// Bench for fp_addsub: exact-arithmetic single-precision model, directed
// vectors pinned to hand-computed values, streaming and mid-flight reset.
module tb_fp_addsub;
  logic clk = 1'b0;
  logic rst;
  int   cyc   = 0;
  int   tests = 0;
  int   fails = 0;

  fp_addsub_if bus ();
  fp_addsub dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        s;
    logic [31:0] res;
    logic [2:0]  flags;   // {overflow, underflow, exception}
    int          due;
  } exp_t;

  exp_t        q[$];
  logic [31:0] last_res   = '0;
  logic [2:0]  last_flags = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %h required %h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Exact sum of the two flushed operands as a wide integer, then one RNE
  // rounding to 24 significant bits.
  function automatic void model(input logic [31:0] a, input logic [31:0] b, input logic s,
                                output logic [31:0] r, output logic [2:0] fl);
    logic         sa, sb, sg;
    int           ea, eb, emin, p, e;
    logic [22:0]  fa, fb;
    logic [299:0] ma, mb, mag, rem, half;
    logic [24:0]  qv;
    sa = a[31]; sb = b[31] ^ s;
    ea = int'(a[30:23]); eb = int'(b[30:23]);
    fa = a[22:0]; fb = b[22:0];
    r = '0; fl = 3'b000;
    if ((ea == 255 && fa != 0) || (eb == 255 && fb != 0) || (ea == 255 && eb == 255 && sa != sb)) begin
      r = 32'h7FC00000; fl = 3'b001; return;
    end
    if (ea == 255) begin r = {sa, 8'hFF, 23'h0}; return; end
    if (eb == 255) begin r = {sb, 8'hFF, 23'h0}; return; end
    if (ea == 0 && eb == 0) begin r = {sa & sb, 31'h0}; return; end
    if (eb == 0) begin r = a; return; end
    if (ea == 0) begin r = {sb, b[30:0]}; return; end
    emin = (ea < eb) ? ea : eb;
    ma = 300'({1'b1, fa}) << (ea - emin);
    mb = 300'({1'b1, fb}) << (eb - emin);
    if (sa == sb) begin mag = ma + mb; sg = sa; end
    else if (ma == mb) begin r = '0; return; end
    else if (ma > mb) begin mag = ma - mb; sg = sa; end
    else begin mag = mb - ma; sg = sb; end
    p = 0;
    for (int i = 0; i < 300; i++) if (mag[i]) p = i;
    e = p + emin - 23;
    if (p > 23) begin
      rem  = mag & ((300'(1) << (p - 23)) - 300'(1));
      half = 300'(1) << (p - 24);
      qv   = 25'(mag >> (p - 23));
      if (rem > half || (rem == half && qv[0])) qv = qv + 25'(1);
      if (qv[24]) begin qv = qv >> 1; e++; end
    end else begin
      qv = 25'(mag << (23 - p));
    end
    if (e >= 255)    begin r = {sg, 8'hFF, 23'h0}; fl = 3'b100; end
    else if (e <= 0) begin r = {sg, 31'h0};        fl = 3'b010; end
    else             r = {sg, 8'(e), qv[22:0]};
  endfunction

  task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic s);
    exp_t e;
    bus.start = 1'b1; bus.op_a = a; bus.op_b = b; bus.sub = s;
    model(a, b, s, e.res, e.flags);
    e.a = a; e.b = b; e.s = s; e.due = cyc + 4;
    q.push_back(e);
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    bus.start = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  // Compare process: every cycle, after the edge.
  initial begin : compare
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (rst) begin
        q.delete();
        chk("reset_done", 32'(bus.done), 32'(0));
        chk("reset_res", bus.res, 32'(0));
        chk("reset_flags", 32'({bus.overflow, bus.underflow, bus.exception}), 32'(0));
        last_res = '0; last_flags = '0;
      end else if (bus.done) begin
        if (q.size() == 0) begin
          tests++; fails++;
          $display("FAIL spurious_done: got done=1 res=%h required done=0 (cycle %0d)", bus.res, cyc);
        end else begin
          e = q.pop_front();
          chk("latency", cyc, e.due);
          chk("res", bus.res, e.res);
          chk("flags", 32'({bus.overflow, bus.underflow, bus.exception}), 32'(e.flags));
          $display("[TB] %h %s %h -> res %h ovf/unf/exc %b (cycle %0d)",
                   e.a, e.s ? "-" : "+", e.b, bus.res,
                   {bus.overflow, bus.underflow, bus.exception}, cyc);
          last_res = e.res; last_flags = e.flags;
        end
      end else begin
        chk("hold_res", bus.res, last_res);
        chk("hold_flags", 32'({bus.overflow, bus.underflow, bus.exception}), 32'(last_flags));
        if (q.size() > 0 && q[0].due <= cyc) begin
          tests++; fails++;
          $display("FAIL missing_done: got done=0 required done=1 for %h op %h (cycle %0d)",
                   q[0].a, q[0].b, cyc);
          q.delete(0);
        end
      end
    end
  end

  localparam int NV = 20;
  logic [31:0] va [NV] = '{32'h3F800000, 32'h3F800000, 32'h00800001, 32'h4B800000, 32'h4B800000,
                           32'h7F7FFFFF, 32'h7F800000, 32'h7FC00001, 32'h80000000, 32'h00000000,
                           32'h40490FDB, 32'h7F800000, 32'h40400000, 32'h3F800000, 32'h00000000,
                           32'hFF800000, 32'h3F800000, 32'h3F800001, 32'h00400000, 32'h3F800000};
  logic [31:0] vb [NV] = '{32'h40000000, 32'h3F800000, 32'h00800000, 32'h3F800000, 32'h40400000,
                           32'h7F7FFFFF, 32'hFF800000, 32'h3F800000, 32'h80000000, 32'h80000000,
                           32'h80000000, 32'h3F800000, 32'h40000000, 32'h40000000, 32'h00000000,
                           32'hFF800000, 32'h33800000, 32'h33800000, 32'h3F800000, 32'hBF800000};
  logic        vs [NV] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                           1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
  logic [31:0] vr [NV] = '{32'h40400000, 32'h00000000, 32'h00000000, 32'h4B800000, 32'h4B800002,
                           32'h7F800000, 32'h7FC00000, 32'h7FC00000, 32'h80000000, 32'h00000000,
                           32'h40490FDB, 32'h7F800000, 32'h3F800000, 32'hBF800000, 32'h00000000,
                           32'h7FC00000, 32'h3F800000, 32'h3F800002, 32'h3F800000, 32'h00000000};
  logic [2:0]  vf [NV] = '{3'b000, 3'b000, 3'b010, 3'b000, 3'b000, 3'b100, 3'b001, 3'b001, 3'b000, 3'b000,
                           3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b001, 3'b000, 3'b000, 3'b000, 3'b000};

  initial begin : stimulus
    logic [31:0] a, b, mr;
    logic [2:0]  mf;
    rst = 1'b1;
    bus.start = 1'b0; bus.sub = 1'b0; bus.op_a = '0; bus.op_b = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Directed vectors, back to back; the model is pinned to each literal.
    for (int i = 0; i < NV; i++) begin
      model(va[i], vb[i], vs[i], mr, mf);
      chk("model_pin_res", mr, vr[i]);
      chk("model_pin_flags", 32'(mf), 32'(vf[i]));
      issue(va[i], vb[i], vs[i]);
    end
    idle(6);

    // Streaming: 8 random ops on consecutive cycles, half with nearby exponents.
    for (int i = 0; i < 8; i++) begin
      a = $urandom;
      b = $urandom;
      if (i % 2 == 0) b[30:23] = a[30:23] ^ 8'($urandom_range(0, 3));
      issue(a, b, 1'($urandom_range(0, 1)));
    end
    idle(6);

    // Reset mid-flight: two ops in flight, third issued while rst is high.
    issue(32'h3F800000, 32'h40000000, 1'b0);
    issue(32'h40400000, 32'h3F800000, 1'b0);
    rst = 1'b1;
    bus.start = 1'b1; bus.op_a = 32'h40A00000; bus.op_b = 32'h3F800000; bus.sub = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    model(32'h40000000, 32'h40000000, 1'b0, mr, mf);
    chk("model_pin_post_reset", mr, 32'h40800000);
    issue(32'h40000000, 32'h40000000, 1'b0);
    idle(1);

    for (int k = 0; k < 20 && q.size() != 0; k++) @(negedge clk);
    if (q.size() != 0) begin
      tests++; fails++;
      $display("FAIL drain: got %0d results outstanding required 0", q.size());
    end
    idle(2);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/fp_addsub.md
FP_ADDSUB -- requirements
Module: fp_addsub

Interface
REQ-001 SHALL have parameter EXP_W, default 8, meaning exponent field width.
REQ-002 SHALL have parameter MAN_W, default 23, meaning stored fraction width; DATA_W = 1+EXP_W+MAN_W, derived, not overridable.
REQ-003 SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port start  input  1  operand-valid strobe, one op accepted per cycle.
REQ-006 SHALL have port sub  input  1  0 = a+b, 1 = a-b, sampled with start.
REQ-007 SHALL have ports op_a, op_b  input  DATA_W  IEEE-754-style operands {sign, exp, frac}, sampled with start.
REQ-008 SHALL have port done  output  1  result-valid strobe.
REQ-009 SHALL have port res  output  DATA_W  result.
REQ-010 SHALL have ports overflow, underflow, exception  output  1 each  status flags qualified by done.

Function
REQ-011 SHALL be fully pipelined, fixed latency 4: start high in cycle N -> done high in cycle N+4 with that op's res/flags; independent ops every cycle, no stalls, no backpressure.
REQ-012 SHALL update res and flags only in cycles where done is driven high; otherwise they hold their last value; done is high for exactly one cycle per accepted op.
REQ-013 SHALL use effective b sign = op_b sign XOR sub.
REQ-014 SHALL treat exp==0 as signed zero (subnormals flushed on input); exp all-ones with frac==0 as signed infinity; exp all-ones with frac!=0 as NaN.
REQ-015 SHALL swap operands so the larger magnitude (exp, then frac) is the reference; result sign = reference sign, except exact cancellation.
REQ-016 SHALL right-shift the smaller significand (hidden 1 restored) by the exponent difference, keeping guard, round and sticky bits; shifts >= MAN_W+3 leave only sticky = OR of all shifted-out bits.
REQ-017 SHALL add or subtract significands per effective signs; carry-out -> shift right 1, exponent +1; otherwise normalise left by leading-zero count, exponent minus count.
REQ-018 SHALL round to nearest, ties to even, using guard/round/sticky; rounding carry-out renormalises (exponent +1).
REQ-019 SHALL return +0 on exact cancellation (x + (-x)); -0 + -0 -> -0; +0 + -0 -> +0; x + 0 -> x exactly.
REQ-020 SHALL, when final exponent >= 2^EXP_W-1 from finite inputs, output signed infinity, overflow=1.
REQ-021 SHALL, when final exponent <= 0 with nonzero result, output signed zero, underflow=1.
REQ-022 SHALL output canonical qNaN (sign 0, exp all-ones, frac MSB 1, rest 0) with exception=1 for any NaN input or inf + (-inf) effective; inf with finite or same-signed inf -> that inf, all flags 0.
REQ-023 SHALL assert at most one of overflow/underflow/exception per result; all 0 for ordinary results.

Reset
REQ-024 SHALL, while rst high, clear all pipeline valid bits and drive done=0, res=0, overflow=0, underflow=0, exception=0 on the next edge.
REQ-025 SHALL discard in-flight ops on reset: no done for any op accepted before or during rst; start sampled with rst high is ignored.
REQ-026 SHALL accept start in the first cycle after rst falls, done 4 cycles later.

Verification
REQ-027 SHALL cover basic add: op_a=0x3F800000, op_b=0x40000000, sub=0 -> done at N+4, res=0x40400000, flags 0.
REQ-028 SHALL cover cancellation/underflow: 1.0-1.0 (sub=1) -> 0x00000000; op_a=0x00800001 minus 0x00800000 -> res=0x00000000, underflow=1.
REQ-029 SHALL cover ties-to-even: 0x4B800000+0x3F800000 -> 0x4B800000; 0x4B800000+0x40400000 -> 0x4B800002.
REQ-030 SHALL cover specials: 0x7F7FFFFF+0x7F7FFFFF -> 0x7F800000, overflow=1; 0x7F800000+0xFF800000 -> 0x7FC00000, exception=1; 0x7FC00001+0x3F800000 -> 0x7FC00000, exception=1.
REQ-031 SHALL cover streaming: 8 random ops on consecutive cycles -> 8 consecutive done pulses, results in order, matching a reference model with flush-to-zero.
REQ-032 SHALL cover reset mid-flight: 3 ops issued, rst high 1 cycle at N+2 -> no done from them; new op at first post-reset cycle -> done 4 cycles later, correct res.
